// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
// Shared definitions for the bit-serial adder: the FSM state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package serial_adder_pkg;

  // IDLE: waiting for start. RUN: one bit per clock. DONE: result strobe.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage : serial_adder_pkg

// File: rtl/full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
// Single-bit full adder cell. Purely combinational.
// Ports:
//   a, b, cin : input  bits to add
//   sum       : output a ^ b ^ cin
//   carry     : output majority(a, b, cin)
// -----------------------------------------------------------------------------
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ cin;
  assign carry = (a & b) | (cin & (a ^ b));

endmodule : full_adder

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
// Bit-serial WIDTH-bit adder. Operands and carry-in are captured on an
// accepted start, then added LSB-first at one bit per clock through a single
// full_adder cell and a carry flop. A one-cycle done strobe follows the last
// bit; sum/cout (and ovf) then hold until the next completion or reset.
//
// Parameters:
//   WIDTH : operand/result width in bits (>= 2), default 8
// Ports:
//   clk   : input  rising-edge clock
//   rst   : input  asynchronous, active-high reset
//   start : input  begin an addition (sampled only in IDLE or DONE)
//   a, b  : input  operands, captured when start is accepted
//   cin   : input  carry-in, captured when start is accepted
//   busy  : output high while bits are being processed
//   done  : output one-cycle strobe, result valid
//   sum   : output last completed result
//   cout  : output carry-out of the last completed result
//   ovf   : output signed overflow of the last result
//           (only when SERIAL_ADDER_OVF_EN is defined)
//
// Build option: define SERIAL_ADDER_OVF_EN to add the ovf port and its flop.
// -----------------------------------------------------------------------------
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int             CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_ss;
  logic             r_c;
  logic [CNT_W-1:0] r_cnt;

  logic             w_load;
  logic             w_step;
  logic             w_last;
  logic             w_fa_sum;
  logic             w_fa_carry;
  logic [WIDTH-1:0] w_ss_next;

  // The one and only adder cell; sequenced over WIDTH clocks.
  full_adder u_fa (
    .a     (r_sa[0]),
    .b     (r_sb[0]),
    .cin   (r_c),
    .sum   (w_fa_sum),
    .carry (w_fa_carry)
  );

  assign w_last = (r_cnt == CNT_LAST);

  // New bit enters at the MSB; after WIDTH steps bit 0 has reached position 0.
  assign w_ss_next = WIDTH'({w_fa_sum, r_ss} >> 1);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        // start is deliberately ignored here: no queueing, no abort.
        w_step = 1'b1;
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // ---------------------------------------------------------------------------
  // Datapath and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the shift registers are cleared on reset as well, so an aborted
      // addition leaves no trace in the datapath.
      r_sa  <= '0;
      r_sb  <= '0;
      r_ss  <= '0;
      r_c   <= 1'b0;
      r_cnt <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      // Status flags are decoded from the next state so they line up with it.
      busy <= (w_state_nxt == S_RUN);
      done <= (w_state_nxt == S_DONE);

      if (w_load) begin
        r_sa  <= a;
        r_sb  <= b;
        r_c   <= cin;
        r_cnt <= '0;
        r_ss  <= '0;
      end else if (w_step) begin
        r_ss  <= w_ss_next;
        r_c   <= w_fa_carry;
        r_sa  <= r_sa >> 1;
        r_sb  <= r_sb >> 1;
        r_cnt <= r_cnt + CNT_W'(1);
        if (w_last) begin
          sum  <= w_ss_next;
          cout <= w_fa_carry;
`ifdef SERIAL_ADDER_OVF_EN
          // During the MSB step r_c is the carry into the MSB.
          ovf  <= r_c ^ w_fa_carry;
`endif
        end
      end
    end
  end

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
// Self-checking bench for serial_adder. Two instances (WIDTH=8 and WIDTH=4)
// are compared every cycle against a cycle-level arithmetic model; directed
// sequences add literal expectations for latency, busy length and results.
// ovf is checked only when SERIAL_ADDER_OVF_EN is defined.
// -----------------------------------------------------------------------------
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b0;

  // Instance 0: WIDTH=8
  logic       st8 = 1'b0, cin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, cout8, ovf8;
  logic [7:0] sum8;
  // Instance 1: WIDTH=4
  logic       st4 = 1'b0, cin4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       busy4, done4, cout4, ovf4;
  logic [3:0] sum4;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst   (rst),
    .start (st8),
    .a     (a8),
    .b     (b8),
    .cin   (cin8),
    .busy  (busy8),
    .done  (done8),
    .sum   (sum8),
    .cout  (cout8)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf8)
`endif
  );

  serial_adder #(.WIDTH(4)) dut4 (
    .clk   (clk),
    .rst   (rst),
    .start (st4),
    .a     (a4),
    .b     (b4),
    .cin   (cin4),
    .busy  (busy4),
    .done  (done4),
    .sum   (sum4),
    .cout  (cout4)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf4)
`endif
  );

`ifndef SERIAL_ADDER_OVF_EN
  assign ovf8 = 1'b0;
  assign ovf4 = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: plain integer arithmetic plus a cycle countdown.
  // ---------------------------------------------------------------------------
  function automatic void ref_add(input int w, input int a, input int b, input int c,
                                  output logic [7:0] s, output logic co, output logic ov);
    int full, half, sa, sb, ssum;
    full = a + b + c;
    s    = 8'(full % (1 << w));
    co   = ((full >> w) & 1) != 0;
    half = 1 << (w - 1);
    sa   = (a >= half) ? a - 2 * half : a;
    sb   = (b >= half) ? b - 2 * half : b;
    ssum = sa + sb + c;
    ov   = (ssum >= half) || (ssum < -half);
  endfunction

  int         m_left [2] = '{0, 0};
  logic       m_done [2] = '{1'b0, 1'b0};
  logic [7:0] m_sum  [2] = '{8'h0, 8'h0};
  logic       m_cout [2] = '{1'b0, 1'b0};
  logic       m_ovf  [2] = '{1'b0, 1'b0};
  logic [7:0] p_sum  [2] = '{8'h0, 8'h0};
  logic       p_cout [2] = '{1'b0, 1'b0};
  logic       p_ovf  [2] = '{1'b0, 1'b0};

  task automatic model_step(input int k, input int w, input logic s,
                            input int a, input int b, input logic c);
    if (m_left[k] > 0) begin
      m_left[k]--;
      m_done[k] = (m_left[k] == 0);
      if (m_left[k] == 0) begin
        m_sum[k]  = p_sum[k];
        m_cout[k] = p_cout[k];
        m_ovf[k]  = p_ovf[k];
      end
    end else begin
      m_done[k] = 1'b0;
      if (s) begin
        m_left[k] = w;
        ref_add(w, a, b, int'(c), p_sum[k], p_cout[k], p_ovf[k]);
      end
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        m_left[k] = 0;
        m_done[k] = 1'b0;
        m_sum[k]  = 8'h0;
        m_cout[k] = 1'b0;
        m_ovf[k]  = 1'b0;
      end
    end else begin
      model_step(0, 8, st8, int'(a8), int'(b8), cin8);
      model_step(1, 4, st4, int'(a4), int'(b4), cin4);
    end
  end

  // Cycle-by-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    check("busy8", 32'(busy8), 32'(m_left[0] > 0));
    check("done8", 32'(done8), 32'(m_done[0]));
    check("sum8",  32'(sum8),  32'(m_sum[0]));
    check("cout8", 32'(cout8), 32'(m_cout[0]));
    check("busy4", 32'(busy4), 32'(m_left[1] > 0));
    check("done4", 32'(done4), 32'(m_done[1]));
    check("sum4",  32'(sum4),  32'(m_sum[1][3:0]));
    check("cout4", 32'(cout4), 32'(m_cout[1]));
`ifdef SERIAL_ADDER_OVF_EN
    check("ovf8",  32'(ovf8),  32'(m_ovf[0]));
    check("ovf4",  32'(ovf4),  32'(m_ovf[1]));
`endif
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (inputs change on negedge only)
  // ---------------------------------------------------------------------------
  task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic c);
    @(negedge clk);
    a8 = a; b8 = b; cin8 = c; st8 = 1'b1;
  endtask

  // Counts negedges from the start-driving negedge until done is seen.
  task automatic wait_done(input int k, output int cyc, output int busy_cyc);
    int seen;
    cyc = 0; busy_cyc = 0; seen = 0;
    while (seen == 0 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        if (k == 0) st8 = 1'b0;
        else        st4 = 1'b0;
      end
      if ((k == 0 && busy8) || (k == 1 && busy4)) busy_cyc++;
      if ((k == 0 && done8) || (k == 1 && done4)) seen = 1;
    end
    check("done_seen", 32'(seen), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, bcyc, n_done, last_done;
    logic [4:0] exp5;

    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy8", 32'(busy8), 32'd0);
    check("rst_done8", 32'(done8), 32'd0);
    check("rst_sum8",  32'(sum8),  32'd0);
    rst = 1'b0;

    // 1: basic 5A + 3C
    start8(8'h5A, 8'h3C, 1'b0);
    wait_done(0, cyc, bcyc);
    check("t1_latency", 32'(cyc), 32'd9);
    check("t1_busy_cycles", 32'(bcyc), 32'd8);
    check("t1_sum", 32'(sum8), 32'h96);
    check("t1_cout", 32'(cout8), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
    check("t1_ovf", 32'(ovf8), 32'd1);
`endif
    @(negedge clk);
    check("t1_done_one_cycle", 32'(done8), 32'd0);
    check("t1_sum_held", 32'(sum8), 32'h96);

    // 2: carry-out boundary, two ways
    start8(8'hFF, 8'h01, 1'b0);
    wait_done(0, cyc, bcyc);
    check("t2a_sum", 32'(sum8), 32'h00);
    check("t2a_cout", 32'(cout8), 32'd1);
`ifdef SERIAL_ADDER_OVF_EN
    check("t2a_ovf", 32'(ovf8), 32'd0);
`endif
    start8(8'h12, 8'h34, 1'b0);   // in between, a different result
    wait_done(0, cyc, bcyc);
    check("t2_mid_sum", 32'(sum8), 32'h46);
    start8(8'hFF, 8'h00, 1'b1);
    wait_done(0, cyc, bcyc);
    check("t2b_sum", 32'(sum8), 32'h00);
    check("t2b_cout", 32'(cout8), 32'd1);

    // 3: start during RUN is ignored
    repeat (2) @(negedge clk);
    start8(8'h5A, 8'h3C, 1'b0);
    @(negedge clk); st8 = 1'b0;
    @(negedge clk); a8 = 8'h01; b8 = 8'h01; st8 = 1'b1;
    @(negedge clk); st8 = 1'b0;
    cyc = 3; n_done = 0;
    while (n_done == 0 && cyc < 40) begin
      @(negedge clk); cyc++;
      if (done8) n_done++;
    end
    check("t3_latency", 32'(cyc), 32'd9);
    check("t3_sum", 32'(sum8), 32'h96);
    n_done = 0;
    repeat (15) begin
      @(negedge clk);
      if (done8) n_done++;
    end
    check("t3_no_second_done", 32'(n_done), 32'd0);

    // 4: start held high continuously
    start8(8'h10, 8'h20, 1'b0);
    n_done = 0; last_done = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (done8) begin
        n_done++;
        check("t4_sum", 32'(sum8), 32'h30);
        if (last_done >= 0) check("t4_period", 32'(c - last_done), 32'd9);
        last_done = c;
      end
    end
    st8 = 1'b0;
    check("t4_done_count", 32'(n_done), 32'd4);
    repeat (12) @(negedge clk);

    // 5: asynchronous reset mid-RUN
    start8(8'h5A, 8'h3C, 1'b0);
    @(negedge clk); st8 = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("t5_busy", 32'(busy8), 32'd0);
    check("t5_done", 32'(done8), 32'd0);
    check("t5_sum", 32'(sum8), 32'd0);
    check("t5_cout", 32'(cout8), 32'd0);
    check("t5_ovf", 32'(ovf8), 32'd0);
    @(negedge clk); rst = 1'b0;
    start8(8'h01, 8'h02, 1'b0);
    wait_done(0, cyc, bcyc);
    check("t5_latency", 32'(cyc), 32'd9);
    check("t5_sum", 32'(sum8), 32'h03);

    // Randomised traffic on the 8-bit instance (model checks every cycle)
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      st8  = ($urandom_range(0, 3) == 0);
      a8   = 8'($urandom);
      b8   = 8'($urandom);
      cin8 = 1'($urandom);
    end
    @(negedge clk); st8 = 1'b0;
    repeat (12) @(negedge clk);

    // 6: exhaustive WIDTH=4 sweep
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int c = 0; c < 2; c++) begin
          @(negedge clk);
          a4 = 4'(a); b4 = 4'(b); cin4 = 1'(c); st4 = 1'b1;
          wait_done(1, cyc, bcyc);
          exp5 = 5'(a + b + c);
          check("t6_sum_cout", 32'({cout4, sum4}), 32'(exp5));
        end
      end
    end
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_serial_adder
